// File: rtl/im_load_arbiter.sv
// im_load_arbiter
// Shares the single port of the 16x32 instruction memory between the fetch
// unit (combinational reads at the PC) and a program loader that streams
// words in over a valid/ready handshake. Write bursts are bounded so that a
// waiting fetch gets one slot after every MAX_BURST accepted words.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   fetch_req/fetch_pc    fetch request and byte address (bits [5:2] used)
//   fetch_gnt/fetch_stall fetch granted this cycle / requested but blocked
//   load_start/base/count begin a load of count (1..16) words at word base
//   load_valid/load_data  loader word offer
//   load_ready            word accepted this cycle when load_valid is high
//   load_busy             load in progress
//   load_done             one-cycle pulse after the final word is written
//   load_err              one-cycle pulse for a rejected load_start
//   im_*                  memory address, write data, write and read strobes
module im_load_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_gnt,
  output logic        fetch_stall,
  input  logic        load_start,
  input  logic [3:0]  load_base,
  input  logic [4:0]  load_count,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err,
  output logic [31:0] im_addr,
  output logic [31:0] im_dataIn,
  output logic        im_memWrite,
  output logic        im_memRead
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    GAP
  } state_t;

  localparam logic [4:0] MAXB = 5'(MAX_BURST);

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [4:0]  remaining_q, remaining_d;
  logic [3:0]  burst_q, burst_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q, load_err_d;

  logic [4:0]  burst_inc;
  logic        count_ok;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;

    burst_inc = {1'b0, burst_q} + 5'd1;
    count_ok  = (load_count != 5'd0) && (load_count <= 5'd16);

    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (count_ok) begin
            ptr_d       = load_base;
            remaining_d = load_count;
            burst_d     = '0;
            state_d     = LOAD;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // load_ready is always high in LOAD, so load_valid alone is an accept.
        if (load_valid) begin
          ptr_d       = ptr_q + 4'd1;
          remaining_d = remaining_q - 5'd1;
          if (remaining_q == 5'd1) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
            burst_d     = '0;
          end else if ((burst_inc >= MAXB) && fetch_req) begin
            // >= also covers a burst that saturated while fetch was idle.
            state_d = GAP;
            burst_d = '0;
          end else if (burst_inc >= MAXB) begin
            burst_d = MAXB[3:0];
          end else begin
            burst_d = burst_inc[3:0];
          end
        end
      end
      GAP: begin
        state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  always_comb begin
    fetch_gnt   = 1'b0;
    fetch_stall = 1'b0;
    load_ready  = 1'b0;
    im_memWrite = 1'b0;
    im_memRead  = 1'b0;
    im_addr     = fetch_pc;
    im_dataIn   = load_data;

    if (state_q == LOAD) begin
      load_ready  = 1'b1;
      fetch_stall = fetch_req;
      im_addr     = {26'b0, ptr_q, 2'b00};
      im_memWrite = load_valid;
    end else begin
      fetch_gnt  = fetch_req;
      im_memRead = fetch_req;
    end

    if (reset) begin
      fetch_gnt   = 1'b0;
      fetch_stall = 1'b0;
      load_ready  = 1'b0;
      im_memWrite = 1'b0;
      im_memRead  = 1'b0;
    end
  end

  assign load_busy = (state_q != IDLE);
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_im_load_arbiter.sv
// Testbench for im_load_arbiter: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a transaction-level reference
// model and a 16-word memory scoreboard.
module tb_im_load_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        load_start = 1'b0;
  logic [3:0]  load_base = '0;
  logic [4:0]  load_count = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        fetch_gnt, fetch_stall, load_ready, load_busy, load_done, load_err;
  logic [31:0] im_addr, im_dataIn;
  logic        im_memWrite, im_memRead;

  always #5 clk = ~clk;

  im_load_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_gnt(fetch_gnt), .fetch_stall(fetch_stall),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err),
    .im_addr(im_addr), .im_dataIn(im_dataIn),
    .im_memWrite(im_memWrite), .im_memRead(im_memRead)
  );

  // Instruction memory: writes on negedge, combinational read.
  logic [31:0] mem [16];
  logic [31:0] instr;
  always @(negedge clk) if (im_memWrite) mem[im_addr[5:2]] <= im_dataIn;
  assign instr = mem[im_addr[5:2]];

  // Reference model state
  bit          m_busy, m_gap, m_done, m_err, acc;
  int          m_next, m_left, m_run;
  logic [31:0] exp_mem [16];
  bit          exp_known [16];
  logic [31:0] wr_q [$];

  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, err_cnt = 0, gap_cnt = 0, start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare one cycle of outputs at negedge, advance the model, move past posedge.
  task automatic step();
    bit nd, ne;
    @(negedge clk);
    if (reset) begin
      check("rst_gnt", fetch_gnt, 0);
      check("rst_stall", fetch_stall, 0);
      check("rst_ready", load_ready, 0);
      check("rst_wr", im_memWrite, 0);
      check("rst_rd", im_memRead, 0);
    end else if (!m_busy || m_gap) begin
      check("gnt", fetch_gnt, fetch_req);
      check("rd", im_memRead, fetch_req);
      check("stall", fetch_stall, 0);
      check("ready", load_ready, 0);
      check("wr", im_memWrite, 0);
      if (fetch_req) begin
        check("faddr", im_addr, fetch_pc);
        if (exp_known[fetch_pc[5:2]]) check("instr", instr, exp_mem[fetch_pc[5:2]]);
      end
    end else begin
      check("gnt_ld", fetch_gnt, 0);
      check("rd_ld", im_memRead, 0);
      check("ready_ld", load_ready, 1);
      check("stall_ld", fetch_stall, fetch_req);
      check("wr_ld", im_memWrite, load_valid);
      if (load_valid) begin
        check("waddr", im_addr, 32'(m_next * 4));
        check("wdata", im_dataIn, load_data);
      end
    end
    check("busy", load_busy, m_busy);
    check("done", load_done, m_done);
    check("err", load_err, m_err);
    if (load_done) begin done_cnt++; done_cyc = cyc; end
    if (load_err) err_cnt++;
    if (!reset && load_busy && !load_ready) gap_cnt++;

    acc = 0; nd = 0; ne = 0;
    if (reset) begin
      m_busy = 0; m_gap = 0; m_run = 0; m_left = 0;
    end else if (!m_busy) begin
      if (load_start) begin
        if (load_count >= 1 && load_count <= 16) begin
          m_busy = 1; m_next = int'(load_base); m_left = int'(load_count); m_run = 0;
        end else ne = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (load_valid) begin
      acc = 1;
      exp_mem[m_next] = load_data;
      exp_known[m_next] = 1;
      wr_q.push_back(load_data);
      m_next = (m_next + 1) % 16;
      m_left--;
      m_run++;
      if (m_left == 0) begin
        m_busy = 0; nd = 1;
      end else if (m_run >= MAXB && fetch_req) begin
        m_gap = 1; m_run = 0;
      end
    end
    m_done = nd; m_err = ne;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Loader holds an offered word until it is taken.
  task automatic drive(input int vprob, input int fprob);
    if (!(load_valid && !acc)) begin
      load_valid = ($urandom_range(99) < vprob);
      load_data  = $urandom;
    end
    fetch_req = ($urandom_range(99) < fprob);
    fetch_pc  = $urandom;
  endtask

  task automatic do_load(input int base, input int count, input int vprob,
                         input int fprob, input int inject_at);
    load_start = 1; load_base = 4'(base); load_count = 5'(count);
    drive(vprob, fprob);
    start_cyc = cyc;
    step();
    load_start = 0;
    for (int n = 0; n < 200 && m_busy; n++) begin
      load_start = (n == inject_at);
      load_count = 5'd3;
      drive(vprob, fprob);
      step();
    end
    load_start = 0;
    check("load_timeout", 32'(m_busy), 0);
  endtask

  initial begin
    @(posedge clk); #1;
    step(); step();

    // Plain fetch after reset
    reset = 0; fetch_req = 1; fetch_pc = 32'h24; #1;
    check("t1_gnt", fetch_gnt, 1);
    check("t1_rd", im_memRead, 1);
    check("t1_addr", im_addr, 32'h24);
    check("t1_busy", load_busy, 0);
    check("t1_done", load_done, 0);
    check("t1_err", load_err, 0);
    step();

    // base 8, count 3, no fetch
    wr_q.delete(); done_cnt = 0;
    do_load(8, 3, 100, 0, -1);
    load_valid = 0; fetch_req = 1; fetch_pc = 32'h28; #1;
    check("t2_gnt", fetch_gnt, 1);
    check("t2_word10", instr, wr_q[2]);
    step(); step();
    check("t2_done_cnt", done_cnt, 1);

    // wrap-around
    wr_q.delete(); done_cnt = 0;
    do_load(14, 4, 100, 0, -1);
    load_valid = 0; fetch_req = 0; step(); step();
    check("t3_done_cnt", done_cnt, 1);
    check("t3_words", wr_q.size(), 4);

    // bounded bursts with fetch held high
    gap_cnt = 0; done_cnt = 0;
    do_load(3, 10, 100, 100, -1);
    step();
    check("t4_done_cycle", done_cyc - start_cyc, 13);
    check("t4_gaps", gap_cnt, 2);
    check("t4_done_cnt", done_cnt, 1);

    // rejected counts and an ignored start during LOAD
    load_valid = 0; fetch_req = 0; err_cnt = 0;
    load_start = 1; load_count = 5'd0; step();
    load_start = 1; load_count = 5'd17; step();
    load_start = 0; step();
    check("t5_err_pulses", err_cnt, 2);
    wr_q.delete(); err_cnt = 0;
    do_load(5, 5, 100, 0, 1);
    step();
    check("t5_ignored_words", wr_q.size(), 5);
    check("t5_no_err", err_cnt, 0);

    // reset after 2 of 6 words
    done_cnt = 0;
    load_start = 1; load_base = 4'd0; load_count = 5'd6; load_valid = 1; fetch_req = 0;
    step();
    load_start = 0; step(); step();
    reset = 1; step();
    reset = 0; load_valid = 0; #1;
    check("t6_ready", load_ready, 0);
    check("t6_busy", load_busy, 0);
    step(); step();
    check("t6_no_done", done_cnt, 0);
    do_load(9, 1, 100, 50, -1);
    step();
    check("t6_done_after", done_cnt, 1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(99) < 1);
      load_start = ($urandom_range(99) < 10);
      load_base  = 4'($urandom);
      load_count = 5'($urandom_range(0, 20));
      drive(70, 50);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_load_arbiter.md
# im_load_arbiter

Arbiter and sequencer for the single port of the 16×32 instruction memory. It shares the port between two requesters: the fetch unit (reads at the PC) and a program loader (streams words in over a valid/ready handshake). It runs bounded write bursts so that fetch is never starved. It sits between the fetch stage, the program-load interface and the instruction memory's address, dataIn, memWrite and memRead inputs.

## Interface
- MAX_BURST, 4 — maximum consecutive accepted load words before one fetch slot is forced while fetch_req is high; legal 1..15.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- fetch_req  in  1  fetch unit wants a read this cycle.
- fetch_pc  in  32  fetch byte address; only bits [5:2] select the word.
- fetch_gnt  out  1  read granted; the instruction bus is valid this cycle.
- fetch_stall  out  1  fetch_req high but not granted.
- load_start  in  1  single-cycle request to begin a load.
- load_base  in  4  first word index.
- load_count  in  5  number of words, 1..16.
- load_valid  in  1  load_data holds a word.
- load_data  in  32  word to write.
- load_ready  out  1  arbiter accepts load_data this cycle.
- load_busy  out  1  a load is in progress.
- load_done  out  1  one-cycle pulse after the final word is written.
- load_err  out  1  one-cycle pulse when a load_start is rejected.
- im_addr  out  32  to memory address input.
- im_dataIn  out  32  to memory dataIn.
- im_memWrite  out  1  to memory memWrite.
- im_memRead  out  1  to memory memRead.

## Operation
- States: IDLE, LOAD, GAP. Registers: ptr[3:0], remaining[4:0], burst[3:0], load_done, load_err.
- Reset: state=IDLE; ptr, remaining and burst = 0; load_done, load_err and load_busy = 0. While reset is high, all combinational outputs are forced to 0: fetch_gnt, fetch_stall, load_ready, im_memWrite, im_memRead.
- IDLE:
  - fetch_gnt=fetch_req; im_memRead=fetch_req; im_addr=fetch_pc; im_memWrite=0; load_ready=0; load_busy=0.
  - On load_start with load_count in 1..16: ptr←load_base, remaining←load_count, burst←0, go to LOAD.
  - On load_start with load_count of 0 or >16: load_err←1 for one cycle; stay in IDLE.
- LOAD:
  - load_busy=1; load_ready=1; fetch_gnt=0; fetch_stall=fetch_req.
  - im_addr={26'b0,ptr,2'b00}; im_dataIn=load_data; im_memWrite=load_valid; im_memRead=0.
  - On accept (load_valid & load_ready): ptr←ptr+1 mod 16 (15 wraps to 0); remaining←remaining−1; burst←burst+1.
  - If remaining==1 at an accept: go to IDLE and load_done←1 (one cycle).
  - Else, if burst+1==MAX_BURST and fetch_req is high: go to GAP and burst←0.
  - If fetch_req is low, burst saturates at MAX_BURST and no GAP occurs. If fetch_req later rises with burst==MAX_BURST, the next accept moves to GAP.
- GAP (one cycle):
  - Drives the port exactly as IDLE does for fetch; load_ready=0; load_busy=1.
  - Unconditionally returns to LOAD.
- load_start outside IDLE is ignored; no load_err.
- A load_valid with no acceptance leaves all load state unchanged. The loader holds load_data until it is accepted.
- The memory captures writes on negedge clk. im_memWrite, im_addr and im_dataIn are stable from the posedge through the following negedge.

## Timing
- load_start sampled at edge T: load_busy=1 and load_ready=1 from cycle T+1.
- Each accepted word costs one cycle. With fetch_req held high, one GAP cycle is inserted after every MAX_BURST words, but never after the final word.
- Final word accepted in cycle C:
  - load_done=1 and load_busy=0 in cycle C+1.
  - Fetch is granted in cycle C+1.
  - Memory contents are visible to fetch from cycle C+1.
- Fetch read latency is combinational: a granted fetch sees the instruction in the same cycle.
- Reset mid-load: state returns to IDLE on that edge, remaining words are abandoned, no load_done is issued. Words already written remain, unless the memory's own reset reloads its init image.
- A load_start arriving in the same cycle as load_done is a new request and is evaluated normally from IDLE.

## Test plan
- Reset, then fetch_req=1 with fetch_pc=0x24 -> fetch_gnt=1, im_memRead=1, im_addr=0x24, load_busy=0, load_done=0, load_err=0.
- load_start with base=8, count=3 and load_valid held, fetch_req=0 -> writes land at words 8, 9, 10 in consecutive cycles; load_done pulses one cycle after the third write; a fetch read of 0x28 then returns the third word.
- base=14, count=4 -> writes land at words 14, 15, 0, 1 (wrap-around); load_done pulses once.
- MAX_BURST=4, count=10, fetch_req=1 throughout -> pattern of 4 writes, GAP (fetch_gnt=1), 4 writes, GAP, 2 writes; load_done in cycle 13 after start; no GAP after the last word.
- load_start with count=0, then count=17 -> load_err pulses each time, state stays IDLE; a load_start issued during LOAD is ignored.
- Reset asserted after 2 of 6 words -> next cycle state is IDLE, load_ready=0, no load_done; a subsequent load of count=1 completes normally.
